// File: rtl/vehicle_pkg.sv
// Shared constants and the speed clamp for the vehicle plant model.
package vehicle_pkg;

  localparam int FUEL_W_DEF   = 4;
  localparam int SPEED_W_DEF  = 8;
  localparam int LAG_MAX      = 16;
  localparam int TICK_DIV_MAX = 256;

  // Clamp a signed intermediate speed into 0..max_val.
  function automatic int sat_speed(input int value, input int max_val);
    if (value < 0) begin
      return 0;
    end else if (value > max_val) begin
      return max_val;
    end
    return value;
  endfunction

endpackage

// File: rtl/vehicle_model_lag_line.sv
// Fixed-depth shift register with synchronous clear, used as the actuation lag.
module lag_line #(
  parameter int W     = 4,
  parameter int DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage_q [DEPTH];
  logic [W-1:0] stage_d [DEPTH];

  // Each stage takes the previous one; stage 0 takes the input.
  always_comb begin
    stage_d[0] = din;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers; reset discards any in-flight samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/vehicle_model.sv
// Clocked vehicle plant: lagged fuel, immediate brake, saturating speed
// integration on a programmable tick. Define VEHICLE_DRAG_EN to subtract
// an aerodynamic drag term (current_speed >> DRAG_SHIFT) on each update.
module vehicle_model
  import vehicle_pkg::*;
#(
  parameter int FUEL_W     = FUEL_W_DEF,
  parameter int SPEED_W    = SPEED_W_DEF,
  parameter int LAG        = 3,
  parameter int TICK_DIV   = 1,
  parameter int DRAG_SHIFT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FUEL_W-1:0]  fuel,
  input  logic [FUEL_W-1:0]  brake,
  output logic [SPEED_W-1:0] current_speed,
  output logic               speed_valid,
  output logic               at_max,
  output logic               at_zero
);

  localparam int SUM_W     = SPEED_W + 2;
  localparam int CNT_W     = $clog2(TICK_DIV_MAX);
  localparam int SPEED_MAX = (1 << SPEED_W) - 1;

  logic [FUEL_W-1:0]  fuel_lagged;
  logic [SPEED_W-1:0] speed_q, speed_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               tick;
  logic [SPEED_W-1:0] drag;
  logic signed [SUM_W-1:0] speed_ext, fuel_ext, brake_ext, drag_ext, sum;

  lag_line #(
    .W     (FUEL_W),
    .DEPTH (LAG)
  ) u_fuel_lag (
    .clk  (clk),
    .rst  (rst),
    .din  (fuel),
    .dout (fuel_lagged)
  );

  // Drag term from the pre-update speed; zero below 2^DRAG_SHIFT by construction.
  always_comb begin
    drag = '0;
`ifdef VEHICLE_DRAG_EN
    drag = speed_q >> DRAG_SHIFT;
`endif
  end

  // Tick generation and saturating speed update.
  always_comb begin
    tick      = (cnt_q == CNT_W'(TICK_DIV - 1));
    cnt_d     = tick ? '0 : cnt_q + 1'b1;
    speed_ext = SUM_W'(speed_q);
    fuel_ext  = SUM_W'(fuel_lagged);
    brake_ext = SUM_W'(brake);
    drag_ext  = SUM_W'(drag);
    sum       = speed_ext + fuel_ext - brake_ext - drag_ext;
    speed_d   = speed_q;
    if (tick) begin
      speed_d = SPEED_W'(sat_speed(int'(sum), SPEED_MAX));
    end
    valid_d   = tick;
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      speed_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      speed_q <= speed_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign current_speed = speed_q;
  assign speed_valid   = valid_q;
  assign at_max        = (speed_q == '1);
  assign at_zero       = (speed_q == '0);

endmodule
